// File: rtl/spatz_tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported TCDM bank between NumInp requesters,
// with grant lock-in under backpressure, a starvation guard and latency-matched response routing.
module spatz_tcdm_bank_arbiter #(
  parameter int unsigned  NumInp                = 4,
  parameter int unsigned  AddrWidth             = 10,
  parameter int unsigned  DataWidth             = 32,
  parameter int unsigned  MemoryResponseLatency = 1,
  parameter int unsigned  MaxStall              = 8,
  localparam int unsigned StrbWidth             = DataWidth / 8,
  localparam int unsigned IdxWidth              = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumInp-1:0]              req_valid_i,
  output logic [NumInp-1:0]              req_ready_o,
  input  logic [NumInp*AddrWidth-1:0]    req_addr_i,
  input  logic [NumInp-1:0]              req_write_i,
  input  logic [NumInp*DataWidth-1:0]    req_data_i,
  input  logic [NumInp*StrbWidth-1:0]    req_strb_i,
  output logic                           mem_valid_o,
  input  logic                           mem_ready_i,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic                           mem_write_o,
  output logic [DataWidth-1:0]           mem_data_o,
  output logic [StrbWidth-1:0]           mem_strb_o,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic [NumInp-1:0]              rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_data_o
);

  localparam int unsigned CntWidth = $clog2(MaxStall + 1);
  localparam logic [NumInp-1:0] OneLsb = {{(NumInp-1){1'b0}}, 1'b1};

  logic [IdxWidth-1:0]   rr_r;
  logic [IdxWidth-1:0]   locked_idx_r;
  logic                  lock_r;
  logic [CntWidth-1:0]   cnt_r [NumInp];
  logic [NumInp-1:0]     rsp_pipe_r [MemoryResponseLatency];

  logic [NumInp-1:0]     starved_s;
  logic [IdxWidth-1:0]   starved_idx_s;
  logic [2*NumInp-1:0]   rot_valid_s;
  logic [IdxWidth-1:0]   rr_idx_s;
  logic [IdxWidth-1:0]   grant_s;
  logic [IdxWidth-1:0]   rr_next_s;
  logic                  hs_s;

  // Grant selection: held lock, then lowest starved requester, then round-robin from rr_r.
  always_comb begin
    starved_s     = {NumInp{1'b0}};
    starved_idx_s = {IdxWidth{1'b0}};
    rr_idx_s      = rr_r;
    rot_valid_s   = {req_valid_i, req_valid_i} >> rr_r;
    // Reverse iteration lets the lowest matching index win the last assignment.
    for (int i = int'(NumInp) - 1; i >= 0; i--) begin
      starved_s[i]  = req_valid_i[i] && (cnt_r[i] == CntWidth'(MaxStall));
      starved_idx_s = starved_s[i] ? IdxWidth'(i) : starved_idx_s;
    end
    for (int k = int'(NumInp) - 1; k >= 0; k--) begin
      rr_idx_s = rot_valid_s[k] ? IdxWidth'((32'(rr_r) + 32'(k)) % NumInp) : rr_idx_s;
    end
    grant_s   = lock_r ? locked_idx_r : ((|starved_s) ? starved_idx_s : rr_idx_s);
    rr_next_s = (grant_s == IdxWidth'(NumInp - 1)) ? {IdxWidth{1'b0}} : grant_s + IdxWidth'(1);
  end

  // Payload mux and per-requester ready for the granted index.
  always_comb begin
    mem_addr_o  = {AddrWidth{1'b0}};
    mem_write_o = 1'b0;
    mem_data_o  = {DataWidth{1'b0}};
    mem_strb_o  = {StrbWidth{1'b0}};
    req_ready_o = {NumInp{1'b0}};
    for (int i = 0; i < int'(NumInp); i++) begin
      mem_addr_o     = (grant_s == IdxWidth'(i)) ? req_addr_i[i*AddrWidth +: AddrWidth] : mem_addr_o;
      mem_write_o    = (grant_s == IdxWidth'(i)) ? req_write_i[i] : mem_write_o;
      mem_data_o     = (grant_s == IdxWidth'(i)) ? req_data_i[i*DataWidth +: DataWidth] : mem_data_o;
      mem_strb_o     = (grant_s == IdxWidth'(i)) ? req_strb_i[i*StrbWidth +: StrbWidth] : mem_strb_o;
      req_ready_o[i] = (grant_s == IdxWidth'(i)) & req_valid_i[i] & mem_ready_i;
    end
  end

  assign mem_valid_o = lock_r | (|req_valid_i);
  assign hs_s        = mem_valid_o & mem_ready_i;

  // Round-robin pointer advance and grant lock-in while the bank stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_r         <= {IdxWidth{1'b0}};
      lock_r       <= 1'b0;
      locked_idx_r <= {IdxWidth{1'b0}};
    end else if (hs_s) begin
      rr_r   <= rr_next_s;
      lock_r <= 1'b0;
    end else if (mem_valid_o) begin
      lock_r       <= 1'b1;
      locked_idx_r <= grant_s;
    end
  end

  // Saturating wait counters; cleared on own handshake or when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumInp); i++) cnt_r[i] <= {CntWidth{1'b0}};
    end else begin
      for (int i = 0; i < int'(NumInp); i++) begin
        if (!req_valid_i[i] || (hs_s && (grant_s == IdxWidth'(i)))) begin
          cnt_r[i] <= {CntWidth{1'b0}};
        end else if (cnt_r[i] != CntWidth'(MaxStall)) begin
          cnt_r[i] <= cnt_r[i] + CntWidth'(1);
        end
      end
    end
  end

  // One-hot response tokens travel alongside the bank read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(MemoryResponseLatency); s++) rsp_pipe_r[s] <= {NumInp{1'b0}};
    end else begin
      rsp_pipe_r[0] <= hs_s ? (OneLsb << grant_s) : {NumInp{1'b0}};
      for (int s = 1; s < int'(MemoryResponseLatency); s++) rsp_pipe_r[s] <= rsp_pipe_r[s-1];
    end
  end

  assign rsp_valid_o = rsp_pipe_r[MemoryResponseLatency-1];
  assign rsp_data_o  = mem_rdata_i;

  spatz_tcdm_bank_arbiter_checker #(
    .NumInp   (NumInp),
    .IdxWidth (IdxWidth)
  ) i_checker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .lock       (lock_r),
    .locked_idx (locked_idx_r),
    .req_valid  (req_valid_i),
    .req_ready  (req_ready_o)
  );

endmodule

// Protocol checks: a locked requester must hold valid, and at most one ready per cycle.
module spatz_tcdm_bank_arbiter_checker #(
  parameter int unsigned NumInp   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                lock,
  input logic [IdxWidth-1:0] locked_idx,
  input logic [NumInp-1:0]   req_valid,
  input logic [NumInp-1:0]   req_ready
);

  a_locked_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock |-> req_valid[locked_idx])
    else $error("requester dropped valid while its grant was locked");

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready))
    else $error("more than one requester ready in a cycle");

endmodule

// File: tb/tb_spatz_tcdm_bank_arbiter.sv
// Randomized bench for spatz_tcdm_bank_arbiter against a cycle-level reference of the
// grant, lock, starvation and response rules, plus directed scenarios.
module tb_spatz_tcdm_bank_arbiter;

  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int LAT = 2;
  localparam int MS  = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_data_i;
  logic [N*SW-1:0] req_strb_i;
  logic            mem_valid_o, mem_ready_i, mem_write_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_data_o, mem_rdata_i, rsp_data_o;
  logic [SW-1:0]   mem_strb_o;

  // Requester state: pend holds a request until the model sees it accepted.
  logic [N-1:0]    pend;
  logic [N-1:0]    wr_a;
  logic [AW-1:0]   addr_a [N];
  logic [DW-1:0]   data_a [N];
  logic [SW-1:0]   strb_a [N];

  typedef struct { int due; int idx; } tok_t;
  tok_t rsp_q[$];
  int   m_rr, m_lidx, m_cnt[N];
  bit   m_lock;
  int   cyc, checks_cnt, errors_cnt;

  always #5 clk_i = ~clk_i;

  assign req_valid_i = pend;
  assign req_write_i = wr_a;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr_i[g*AW +: AW] = addr_a[g];
    assign req_data_i[g*DW +: DW] = data_a[g];
    assign req_strb_i[g*SW +: SW] = strb_a[g];
  end

  spatz_tcdm_bank_arbiter #(
    .NumInp(N), .AddrWidth(AW), .DataWidth(DW),
    .MemoryResponseLatency(LAT), .MaxStall(MS)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_data_i(req_data_i), .req_strb_i(req_strb_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_write_o(mem_write_o),
    .mem_data_o(mem_data_o), .mem_strb_o(mem_strb_o),
    .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    pend[i]   = 1'b1;
    wr_a[i]   = w;
    addr_a[i] = a;
    data_a[i] = d;
    strb_a[i] = s;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom()), $urandom(), SW'($urandom()));
  endtask

  // Who should own the bank this cycle: held grant, starved requester, or next in rotation.
  function automatic int model_grant();
    if (m_lock) return m_lidx;
    for (int i = 0; i < N; i++) if (pend[i] && m_cnt[i] == MS) return i;
    for (int k = 0; k < N; k++) if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  // Called at a falling edge with inputs set; checks this cycle, then advances the model.
  task automatic run_cycle();
    int g;
    bit any, hs;
    logic [N-1:0] exp_rdy, exp_rsp;
    mem_rdata_i = $urandom();
    #1;
    g   = model_grant();
    any = (g >= 0);
    exp_rsp = '0;
    while (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_rsp[rsp_q[0].idx] = 1'b1;
      rsp_q.delete(0);
    end
    check_val("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp));
    if (exp_rsp != '0) check_val("rsp_data", 64'(rsp_data_o), 64'(mem_rdata_i));
    check_val("mem_valid", 64'(mem_valid_o), 64'(any));
    exp_rdy = '0;
    if (any && mem_ready_i) exp_rdy[g] = 1'b1;
    check_val("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    if (any) begin
      check_val("mem_addr",  64'(mem_addr_o),  64'(addr_a[g]));
      check_val("mem_write", 64'(mem_write_o), 64'(wr_a[g]));
      check_val("mem_data",  64'(mem_data_o),  64'(data_a[g]));
      check_val("mem_strb",  64'(mem_strb_o),  64'(strb_a[g]));
    end
    hs = any && mem_ready_i;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] || (hs && g == i)) m_cnt[i] = 0;
      else m_cnt[i] = (m_cnt[i] + 1 > MS) ? MS : m_cnt[i] + 1;
    end
    if (hs) begin
      m_rr   = (g + 1) % N;
      m_lock = 1'b0;
      rsp_q.push_back('{cyc + LAT, g});
    end else if (any) begin
      m_lock = 1'b1;
      m_lidx = g;
    end
    cyc++;
    @(negedge clk_i);
    if (hs) pend[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    pend        = '0;
    mem_ready_i = 1'b0;
    m_rr        = 0;
    m_lock      = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rsp_q.delete();
    repeat (2) @(negedge clk_i);
    #1;
    check_val("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_val("rst_mem_valid", 64'(mem_valid_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic drain();
    mem_ready_i = 1'b1;
    for (int k = 0; k < 20 && pend != '0; k++) run_cycle();
    repeat (LAT + 1) run_cycle();
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    cyc         = 0;
    wr_a        = '0;
    mem_rdata_i = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
      strb_a[i] = '0;
    end
    do_reset();
    run_cycle();

    // All requesters valid, bank always ready: strict rotation with in-order responses.
    mem_ready_i = 1'b1;
    repeat (10) begin
      for (int i = 0; i < N; i++) if (!pend[i]) set_rand_req(i);
      run_cycle();
    end
    drain();

    // Bank stalls on a lone requester 2; a later requester 0 must wait for its turn.
    set_req(2, 1'b0, 10'h2A5, 32'h0, 4'hF);
    mem_ready_i = 1'b0;
    repeat (3) run_cycle();
    set_req(0, 1'b0, 10'h011, 32'h0, 4'hF);
    run_cycle();
    mem_ready_i = 1'b1;
    run_cycle();
    run_cycle();
    drain();

    // Strobed write from requester 0.
    set_req(0, 1'b1, 10'h100, 32'hDEADBEEF, 4'b0101);
    #1;
    check_val("wr_strb", 64'(mem_strb_o), 64'h5);
    check_val("wr_data", 64'(mem_data_o), 64'hDEADBEEF);
    run_cycle();
    drain();

    // Random traffic with moderate and heavy backpressure.
    repeat (1500) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) set_rand_req(i);
      mem_ready_i = ($urandom_range(0, 9) < 6);
      run_cycle();
    end
    repeat (600) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) != 0) set_rand_req(i);
      mem_ready_i = ($urandom_range(0, 9) < 2);
      run_cycle();
    end
    drain();

    // Reset one cycle after a read handshake: its response must never appear.
    set_req(1, 1'b0, 10'h3C3, 32'h0, 4'hF);
    mem_ready_i = 1'b1;
    run_cycle();
    do_reset();
    repeat (LAT + 2) run_cycle();
    set_req(3, 1'b0, 10'h033, 32'h0, 4'hF);
    set_req(1, 1'b0, 10'h011, 32'h0, 4'hF);
    mem_ready_i = 1'b1;
    #1;
    check_val("post_rst_grant", 64'(req_ready_o), 64'b0010);
    run_cycle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
